// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and a word-organised data RAM.
// Sub-word stores are read-modify-write; word-spanning accesses split into two RAM accesses.
module mem_access_unit #(
  parameter int DEPTH_WORDS      = 128,
  parameter int IDX_W            = 7,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [1:0]  ram_write_flag,
  output logic [2:0]  ram_load_flag,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, LD0, LD1, SRD0, SWR0, SRD1, SWR1, RESP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic              span_q;
  logic [7:0]        mask_q;
  logic [63:0]       wdata_q;
  logic [31:0]       buf0;

  logic [IDX_W-1:0]  in_idx;
  logic [1:0]        in_off;
  logic              in_span;
  logic              in_err;
  logic [7:0]        in_mask;
  logic [63:0]       in_wshift;
  logic [IDX_W-1:0]  next_idx;
  logic              unused_addr_bits;

  assign req_ready = rst && (state == IDLE);

  assign in_idx    = req_addr[IDX_W+1:2];
  assign in_off    = req_addr[1:0];
  assign in_span   = ((req_size == 2'b01) && (in_off == 2'd3)) ||
                     ((req_size == 2'b10) && (in_off != 2'd0));
  assign in_err    = (req_size == 2'b11) || (in_span && (ALLOW_MISALIGNED == 0));
  assign in_mask   = ((req_size == 2'b00) ? 8'h01 : (req_size == 2'b01) ? 8'h03 : 8'h0F) << in_off;
  assign in_wshift = {32'h0, req_wdata} << {in_off, 3'b000};
  assign next_idx  = (idx_q == IDX_W'(DEPTH_WORDS - 1)) ? '0 : idx_q + 1'b1;

  assign unused_addr_bits = ^req_addr[31:IDX_W+2];

  // Pull the addressed lanes out of the two-word window and extend to 32 bits.
  function automatic logic [31:0] extract(input logic [63:0] win, input logic [1:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [63:0] sh;
    logic [31:0] res;
    sh = win >> {off, 3'b000};
    case (size)
      2'b00:   res = {{24{sgn & sh[7]}}, sh[7:0]};
      2'b01:   res = {{16{sgn & sh[15]}}, sh[15:0]};
      default: res = sh[31:0];
    endcase
    return res;
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic hi,
                                             input logic [7:0] mask, input logic [63:0] win);
    logic [31:0] res;
    int          l;
    res = old;
    for (int i = 0; i < 4; i++) begin
      l = hi ? i + 4 : i;
      if (mask[l]) res[8*i +: 8] = win[8*l +: 8];
    end
    return res;
  endfunction

  // Sequencer: every RAM and response output is registered here; flags default to idle each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      idx_q          <= '0;
      off_q          <= '0;
      size_q         <= '0;
      signed_q       <= 1'b0;
      span_q         <= 1'b0;
      mask_q         <= '0;
      wdata_q        <= '0;
      buf0           <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_write_flag <= 2'b00;
      ram_load_flag  <= 3'b000;
    end else begin
      ram_write_flag <= 2'b00;
      ram_load_flag  <= 3'b000;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            idx_q    <= in_idx;
            off_q    <= in_off;
            size_q   <= req_size;
            signed_q <= req_signed;
            span_q   <= in_span;
            mask_q   <= in_mask;
            wdata_q  <= in_wshift;
            if (in_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_we) begin
              state         <= LD0;
              ram_load_flag <= 3'b001;
              ram_addr      <= 32'(in_idx);
            end else if ((req_size == 2'b10) && (in_off == 2'd0)) begin
              state          <= SWR0;
              ram_write_flag <= 2'b01;
              ram_addr       <= 32'(in_idx);
              ram_wdata      <= req_wdata;
            end else begin
              state         <= SRD0;
              ram_load_flag <= 3'b001;
              ram_addr      <= 32'(in_idx);
            end
          end
        end
        LD0: begin
          buf0 <= ram_rdata;
          if (span_q) begin
            state         <= LD1;
            ram_load_flag <= 3'b001;
            ram_addr      <= 32'(next_idx);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= extract({32'h0, ram_rdata}, off_q, size_q, signed_q);
          end
        end
        LD1: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= extract({ram_rdata, buf0}, off_q, size_q, signed_q);
        end
        SRD0: begin
          state          <= SWR0;
          ram_write_flag <= 2'b01;
          ram_wdata      <= merge_word(ram_rdata, 1'b0, mask_q, wdata_q);
        end
        SWR0: begin
          if (span_q) begin
            state         <= SRD1;
            ram_load_flag <= 3'b001;
            ram_addr      <= 32'(next_idx);
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        SRD1: begin
          state          <= SWR1;
          ram_write_flag <= 2'b01;
          ram_wdata      <= merge_word(ram_rdata, 1'b1, mask_q, wdata_q);
        end
        SWR1: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-level reference memory predicts every response.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_valid2 = 1'b0;
  logic        req_ready, req_ready2;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_valid2;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata, resp_rdata2;
  logic        resp_err, resp_err2;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, ram_addr2, ram_wdata2;
  logic [1:0]  ram_write_flag, ram_write_flag2;
  logic [2:0]  ram_load_flag, ram_load_flag2;

  logic [31:0] mem [128];
  logic [31:0] ref_mem [128];
  logic        pre_we = 1'b0;
  logic [6:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  int          n_reads = 0, n_writes = 0, n_act2 = 0;
  logic [6:0]  rd_log [$];

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb [$];

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH_WORDS(128), .IDX_W(7), .ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_write_flag(ram_write_flag),
    .ram_load_flag(ram_load_flag), .ram_rdata(ram_rdata));

  mem_access_unit #(.DEPTH_WORDS(128), .IDX_W(7), .ALLOW_MISALIGNED(0)) dut_strict (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid2), .resp_ready(resp_ready), .resp_rdata(resp_rdata2), .resp_err(resp_err2),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_write_flag(ram_write_flag2),
    .ram_load_flag(ram_load_flag2), .ram_rdata(32'h0));

  assign ram_rdata = mem[ram_addr[6:0]];

  // RAM model with a bench-side preload port and access counters.
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    if (ram_write_flag == 2'b01) begin
      mem[ram_addr[6:0]] <= ram_wdata;
      n_writes++;
    end
    if (ram_load_flag == 3'b001) begin
      n_reads++;
      rd_log.push_back(ram_addr[6:0]);
    end
    if (ram_write_flag2 != 2'b00 || ram_load_flag2 != 3'b000) n_act2++;
  end

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 7'(i); pre_data = v;
    ref_mem[i] = v;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  function automatic exp_t model(input logic we, input logic [1:0] size, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   base, n, a;
    logic span;
    logic [31:0] v;
    e.rdata = '0; e.err = 1'b0;
    base = int'(addr[8:0]);
    n    = 1 << size;
    span = ((base & 3) + n) > 4;
    if (size == 2'b11) begin
      e.err = 1'b1; e.lat = 1;
      return e;
    end
    v = '0;
    for (int i = 0; i < n; i++) begin
      a = (base + i) & 511;
      if (we) ref_mem[a >> 2][8*(a & 3) +: 8] = wdata[8*i +: 8];
      else    v[8*i +: 8] = ref_mem[a >> 2][8*(a & 3) +: 8];
    end
    if (!we) begin
      if (sgn && size == 2'b00 && v[7])  v = v | 32'hFFFFFF00;
      if (sgn && size == 2'b01 && v[15]) v = v | 32'hFFFF0000;
      e.rdata = v;
      e.lat   = span ? 3 : 2;
    end else begin
      e.lat = (size == 2'b10 && (base & 3) == 0) ? 2 : (span ? 5 : 3);
    end
    return e;
  endfunction

  // Drive one request, then compare its response against the scoreboard head.
  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int stall, output logic [31:0] rd);
    exp_t e;
    int   lat;
    sb.push_back(model(we, size, sgn, addr, wdata));
    @(negedge clk);
    check_output("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    e  = sb.pop_front();
    rd = resp_rdata;
    if (!resp_valid) begin
      check_output("resp_timeout", 32'(resp_valid), 32'd1);
      return;
    end
    check_output("rdata", resp_rdata, e.rdata);
    check_output("err", 32'(resp_err), 32'(e.err));
    check_output("latency", 32'(lat), 32'(e.lat));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); @(negedge clk);
      check_output("stall_valid", 32'(resp_valid), 32'd1);
      check_output("stall_rdata", resp_rdata, e.rdata);
      check_output("stall_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check_output("resp_drop", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    int          r0, w0;
    logic [1:0]  sz;
    logic        we;

    for (int i = 0; i < 128; i++) set_word(i, 32'h0101_0101 * i ^ 32'h5A00_00A5);
    @(negedge clk);
    check_output("rst_ready", 32'(req_ready), 32'd0);
    check_output("rst_valid", 32'(resp_valid), 32'd0);
    check_output("rst_flags", {27'd0, ram_load_flag, ram_write_flag}, 32'd0);
    check_output("rst_addr", ram_addr, 32'd0);
    check_output("rst_wdata", ram_wdata, 32'd0);
    rst = 1'b1;
    #1;
    check_output("rel_ready", 32'(req_ready), 32'd1);

    set_word(0, 32'h12345678);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, rd);
    check_output("lw0", rd, 32'h12345678);

    set_word(4, 32'hF2345678);
    apply_stimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, rd);
    check_output("lb_s", rd, 32'hFFFFFFF2);
    apply_stimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0, rd);
    check_output("lbu", rd, 32'h000000F2);

    r0 = n_reads; w0 = n_writes;
    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h2, 32'hAAAABEEF, 0, rd);
    check_output("sh_word0", mem[0], 32'hBEEF5678);
    check_output("sh_reads", 32'(n_reads - r0), 32'd1);
    check_output("sh_writes", 32'(n_writes - w0), 32'd1);

    set_word(1, 32'h22222222);
    set_word(2, 32'h33333333);
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h5, 32'h0, 3, rd);
    check_output("lw_span", rd, 32'h33222222);
    w0 = n_writes;
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h7, 32'h11223344, 0, rd);
    check_output("sw_w1", mem[1], 32'h44222222);
    check_output("sw_w2", mem[2], 32'h33112233);
    check_output("sw_writes", 32'(n_writes - w0), 32'd2);

    set_word(127, 32'hAABBCCDD);
    set_word(0, 32'h11223344);
    rd_log.delete();
    apply_stimulus(1'b0, 2'b10, 1'b0, 32'h1FE, 32'h0, 0, rd);
    check_output("wrap_data", rd, 32'h3344AABB);
    check_output("wrap_nrd", 32'(rd_log.size()), 32'd2);
    if (rd_log.size() == 2) begin
      check_output("wrap_rd0", 32'(rd_log[0]), 32'd127);
      check_output("wrap_rd1", 32'(rd_log[1]), 32'd0);
    end

    apply_stimulus(1'b0, 2'b01, 1'b1, 32'h0000_0107, 32'h0, 0, rd);
    r0 = n_reads;
    apply_stimulus(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 0, rd);
    check_output("rsv_reads", 32'(n_reads - r0), 32'd0);

    for (int k = 0; k < 24; k++) begin
      sz = 2'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      apply_stimulus(we, sz, 1'($urandom_range(0, 1)), $urandom(), $urandom(), k % 3, rd);
    end

    set_word(10, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h28; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_output("swr0_flag", 32'(ram_write_flag), 32'd1);
    w0 = n_writes;
    rst = 1'b0;
    #1;
    check_output("abort_flag", 32'(ram_write_flag), 32'd0);
    check_output("abort_ready", 32'(req_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("abort_rel_ready", 32'(req_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    check_output("abort_valid", 32'(resp_valid), 32'd0);
    check_output("abort_writes", 32'(n_writes - w0), 32'd0);
    check_output("abort_mem", mem[10], 32'hCAFEF00D);

    @(negedge clk);
    req_valid2 = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h1;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    @(negedge clk);
    check_output("strict_valid", 32'(resp_valid2), 32'd1);
    check_output("strict_err", 32'(resp_err2), 32'd1);
    check_output("strict_rdata", resp_rdata2, 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check_output("strict_drop", 32'(resp_valid2), 32'd0);
    check_output("strict_ram", 32'(n_act2), 32'd0);

    for (int i = 0; i < 128; i++) check_output($sformatf("mem%0d", i), mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
